// File: rtl/strela_obi_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : strela_obi_arbiter
// Brief    : Round-robin share of one OBI master port among NUM_REQ memory
//            nodes, with in-order response routing through an ID FIFO.
// Revision : 1.0
// ============================================================================
module strela_obi_arbiter #(
  parameter int NUM_REQ   = 8,
  parameter int MAX_OUTST = 2,
  // Packed OBI request : {req, we, be[3:0], addr[31:0], wdata[31:0]}
  localparam int REQ_W  = 70,
  // Packed OBI response: {gnt, rvalid, rdata[31:0]}
  localparam int RESP_W = 34,
  localparam int IDW    = $clog2(NUM_REQ)
) (
  input  logic                        clk_i,
  input  logic                        rst_ni,
  input  logic                        clr_i,
  input  logic [NUM_REQ*REQ_W-1:0]    slaves_req_i,
  output logic [NUM_REQ*RESP_W-1:0]   slaves_resp_o,
  output logic [REQ_W-1:0]            master_req_o,
  input  logic [RESP_W-1:0]           master_resp_i,
  output logic                        busy_o,
  output logic                        err_o
);

  localparam int PW = (MAX_OUTST > 1) ? $clog2(MAX_OUTST) : 1;
  localparam int CW = $clog2(MAX_OUTST + 1);

  localparam logic [PW-1:0]  c_last_ptr = PW'(MAX_OUTST - 1);
  localparam logic [CW-1:0]  c_full     = CW'(MAX_OUTST);
  localparam logic [IDW:0]   c_num_req  = (IDW+1)'(NUM_REQ);
  localparam logic [IDW-1:0] c_last_idx = IDW'(NUM_REQ - 1);

  logic [IDW-1:0] r_rr;
  logic           r_lock;
  logic [IDW-1:0] r_lock_idx;
  logic [IDW-1:0] r_fifo [MAX_OUTST];
  logic [PW-1:0]  r_wptr;
  logic [PW-1:0]  r_rptr;
  logic [CW-1:0]  r_count;
  logic           r_busy;
  logic           r_err;

  logic [NUM_REQ-1:0] w_req;
  logic [REQ_W-2:0]   w_fields [NUM_REQ];
  logic [IDW-1:0]     w_search;
  logic [IDW:0]       w_cand;
  logic [IDW-1:0]     w_winner;
  logic [IDW-1:0]     w_head;
  logic               w_stall;
  logic               w_mreq;
  logic               w_hs;
  logic               w_rvalid;
  logic               w_pop;
  logic               w_spurious;
  logic [CW-1:0]      w_count_nxt;

  for (genvar g = 0; g < NUM_REQ; g++) begin : g_req
    assign w_req[g]    = slaves_req_i[g*REQ_W + REQ_W - 1];
    assign w_fields[g] = slaves_req_i[g*REQ_W +: REQ_W - 1];
  end

  // Descending scan so the requester closest to r_rr is the last one kept.
  always_comb begin
    w_search = '0;
    w_cand   = '0;
    for (int i = NUM_REQ - 1; i >= 0; i--) begin
      w_cand = {1'b0, r_rr} + (IDW+1)'(i);
      if (w_cand >= c_num_req) begin
        w_cand = w_cand - c_num_req;
      end
      if (w_req[w_cand[IDW-1:0]]) begin
        w_search = w_cand[IDW-1:0];
      end
    end
  end

  assign w_winner   = r_lock ? r_lock_idx : w_search;
  assign w_stall    = (r_count == c_full);
  assign w_mreq     = w_req[w_winner] & ~w_stall;
  assign w_hs       = w_mreq & master_resp_i[RESP_W-1];
  assign w_rvalid   = master_resp_i[RESP_W-2];
  assign w_pop      = w_rvalid & (r_count != '0);
  assign w_spurious = w_rvalid & (r_count == '0);
  assign w_head     = r_fifo[r_rptr];

  assign master_req_o = {w_mreq, w_fields[w_winner]};

  for (genvar g = 0; g < NUM_REQ; g++) begin : g_resp
    assign slaves_resp_o[g*RESP_W +: RESP_W] = {
      w_hs  & (w_winner == IDW'(g)),
      w_pop & (w_head   == IDW'(g)),
      master_resp_i[31:0]
    };
  end

  always_comb begin
    w_count_nxt = r_count;
    if (w_hs && !w_pop) begin
      w_count_nxt = r_count + CW'(1);
    end else if (!w_hs && w_pop) begin
      w_count_nxt = r_count - CW'(1);
    end
  end

  // ID storage needs no reset: entries are only read while r_count != 0.
  always_ff @(posedge clk_i) begin
    if (w_hs && !clr_i) begin
      r_fifo[r_wptr] <= w_winner;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_rr       <= '0;
      r_lock     <= 1'b0;
      r_lock_idx <= '0;
      r_wptr     <= '0;
      r_rptr     <= '0;
      r_count    <= '0;
      r_busy     <= 1'b0;
      r_err      <= 1'b0;
    end else if (clr_i) begin
      r_rr       <= '0;
      r_lock     <= 1'b0;
      r_lock_idx <= '0;
      r_wptr     <= '0;
      r_rptr     <= '0;
      r_count    <= '0;
      r_busy     <= 1'b0;
      r_err      <= 1'b0;
    end else begin
      if (w_hs) begin
        r_wptr <= (r_wptr == c_last_ptr) ? '0 : r_wptr + PW'(1);
        r_rr   <= (w_winner == c_last_idx) ? '0 : w_winner + IDW'(1);
        r_lock <= 1'b0;
      end else if (w_mreq) begin
        // Presented but not granted: hold this requester until it is taken.
        r_lock     <= 1'b1;
        r_lock_idx <= w_winner;
      end
      if (w_pop) begin
        r_rptr <= (r_rptr == c_last_ptr) ? '0 : r_rptr + PW'(1);
      end
      if (w_spurious) begin
        r_err <= 1'b1;
      end
      r_count <= w_count_nxt;
      r_busy  <= (w_count_nxt != '0);
    end
  end

  assign busy_o = r_busy;
  assign err_o  = r_err;

endmodule
`default_nettype wire

// File: tb/tb_strela_obi_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : tb_strela_obi_arbiter
// Brief    : Scoreboard bench for strela_obi_arbiter against a queue model.
// Revision : 1.0
// ============================================================================
module tb_strela_obi_arbiter;

  localparam int NUM_REQ   = 8;
  localparam int MAX_OUTST = 2;
  localparam int REQ_W     = 70;
  localparam int RESP_W    = 34;

  logic                      clk = 1'b0;
  logic                      rst_ni;
  logic                      clr_i;
  logic [NUM_REQ*REQ_W-1:0]  slaves_req_i;
  logic [NUM_REQ*RESP_W-1:0] slaves_resp_o;
  logic [REQ_W-1:0]          master_req_o;
  logic [RESP_W-1:0]         master_resp_i;
  logic                      busy_o;
  logic                      err_o;

  strela_obi_arbiter #(.NUM_REQ(NUM_REQ), .MAX_OUTST(MAX_OUTST)) dut (
    .clk_i        (clk),
    .rst_ni       (rst_ni),
    .clr_i        (clr_i),
    .slaves_req_i (slaves_req_i),
    .slaves_resp_o(slaves_resp_o),
    .master_req_o (master_req_o),
    .master_resp_i(master_resp_i),
    .busy_o       (busy_o),
    .err_o        (err_o)
  );

  always #5 clk = ~clk;

  // Node side: a pending request is held with stable fields until granted.
  bit          pend [NUM_REQ];
  logic [68:0] fld  [NUM_REQ];

  // Reference model: rotating priority, lock holder, queue of outstanding IDs.
  int rr;
  int lock_idx;
  bit m_err;
  int outst[$];

  typedef struct packed { logic [31:0] node; logic [68:0] f; } gnt_t;
  typedef struct packed { logic [31:0] node; logic [31:0] d; } rsp_t;
  typedef struct packed { bit mreq; bit busy; bit err; } cyc_t;

  gnt_t gnt_q[$];
  rsp_t rsp_q[$];
  cyc_t cyc_q[$];
  int   gnt_log[$];

  int total = 0;
  int bad   = 0;

  task automatic check(input string name, input logic [69:0] act, input logic [69:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  function automatic int pick();
    if (lock_idx >= 0) return lock_idx;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (pend[(rr + i) % NUM_REQ]) return (rr + i) % NUM_REQ;
    end
    return -1;
  endfunction

  function automatic logic [68:0] rnd_fld();
    logic [68:0] f;
    f = {1'($urandom), 4'($urandom), 32'($urandom), 32'($urandom)};
    return f;
  endfunction

  task automatic model_clear();
    outst.delete();
    rr       = 0;
    lock_idx = -1;
    m_err    = 1'b0;
  endtask

  task automatic arm(input int k, input logic [68:0] f);
    if (!pend[k]) begin
      pend[k] = 1'b1;
      fld[k]  = f;
    end
  endtask

  task automatic drive(input bit g, input bit rv, input logic [31:0] rd, input bit c);
    for (int k = 0; k < NUM_REQ; k++) slaves_req_i[k*REQ_W +: REQ_W] = {pend[k], fld[k]};
    master_resp_i = {g, rv, rd};
    clr_i         = c;
  endtask

  // One bus cycle: drive, predict what the DUT must show, advance the model.
  task automatic step(input bit g, input bit rv, input logic [31:0] rd, input bit c);
    int   w;
    bit   mreq;
    cyc_t cr;
    gnt_t eg;
    rsp_t er;
    @(posedge clk);
    #1;
    drive(g, rv, rd, c);
    w    = pick();
    mreq = (w >= 0) && pend[w] && (outst.size() < MAX_OUTST);
    cr.mreq = mreq;
    cr.busy = (outst.size() != 0);
    cr.err  = m_err;
    cyc_q.push_back(cr);
    if (rv) begin
      if (outst.size() != 0) begin
        er.node = 32'(outst[0]);
        er.d    = rd;
        rsp_q.push_back(er);
        void'(outst.pop_front());
      end else begin
        m_err = 1'b1;
      end
    end
    if (mreq && g) begin
      eg.node = 32'(w);
      eg.f    = fld[w];
      gnt_q.push_back(eg);
      pend[w] = 1'b0;
      outst.push_back(w);
      rr       = (w + 1) % NUM_REQ;
      lock_idx = -1;
    end else if (mreq) begin
      lock_idx = w;
    end
    if (c) model_clear();
  endtask

  task automatic do_reset();
    @(negedge clk);
    #1;
    for (int k = 0; k < NUM_REQ; k++) pend[k] = 1'b0;
    drive(1'b0, 1'b0, 32'h0, 1'b0);
    check("drained", 70'(gnt_q.size() + rsp_q.size()), 70'(0));
    rst_ni = 1'b0;
    #1;
    check("rst_busy", 70'(busy_o), 70'(0));
    check("rst_err", 70'(err_o), 70'(0));
    model_clear();
    gnt_q.delete();
    rsp_q.delete();
    cyc_q.delete();
    gnt_log.delete();
    #1 rst_ni = 1'b1;
  endtask

  // Monitor: pops expectations whenever the DUT presents a gnt or rvalid.
  always @(negedge clk) begin : mon
    int   ng;
    int   nr;
    int   kg;
    int   kr;
    cyc_t cr;
    gnt_t eg;
    rsp_t er;
    ng = 0; nr = 0; kg = -1; kr = -1;
    for (int k = 0; k < NUM_REQ; k++) begin
      if (slaves_resp_o[k*RESP_W + 33] === 1'b1) begin ng++; kg = k; end
      if (slaves_resp_o[k*RESP_W + 32] === 1'b1) begin nr++; kr = k; end
    end
    if (ng > 1 || nr > 1) begin
      total++; bad++;
      $display("FAIL onehot: gnt count %0d rvalid count %0d, at most 1 allowed", ng, nr);
    end
    if (kg >= 0) begin
      if (gnt_q.size() == 0) begin
        total++; bad++;
        $display("FAIL unexpected_gnt: node %0d granted, none expected", kg);
      end else begin
        eg = gnt_q.pop_front();
        gnt_log.push_back(kg);
        check("gnt_node", 70'(kg), 70'(eg.node));
        check("gnt_fields", master_req_o, {1'b1, eg.f});
      end
    end
    if (kr >= 0) begin
      if (rsp_q.size() == 0) begin
        total++; bad++;
        $display("FAIL unexpected_rvalid: node %0d got rvalid, none expected", kr);
      end else begin
        er = rsp_q.pop_front();
        check("rsp_node", 70'(kr), 70'(er.node));
        for (int k = 0; k < NUM_REQ; k++)
          check("rsp_rdata", 70'(slaves_resp_o[k*RESP_W +: 32]), 70'(er.d));
      end
    end
    if (cyc_q.size() != 0) begin
      cr = cyc_q.pop_front();
      check("master_req", 70'(master_req_o[69]), 70'(cr.mreq));
      check("busy", 70'(busy_o), 70'(cr.busy));
      check("err", 70'(err_o), 70'(cr.err));
    end
  end

  initial begin : main
    bit          g;
    bit          rv;
    logic [68:0] f1;
    int          exp_fair [6];
    logic [31:0] rdv;

    for (int k = 0; k < NUM_REQ; k++) begin pend[k] = 1'b0; fld[k] = '0; end
    model_clear();
    rst_ni = 1'b0;
    drive(1'b0, 1'b1, 32'hDEAD_BEEF, 1'b0);
    #1;
    for (int k = 0; k < NUM_REQ; k++)
      check("rst_rvalid", 70'(slaves_resp_o[k*RESP_W + 32]), 70'(0));
    check("rst_busy0", 70'(busy_o), 70'(0));
    check("rst_err0", 70'(err_o), 70'(0));
    drive(1'b0, 1'b0, 32'h0, 1'b0);
    #11 rst_ni = 1'b1;

    // Single requester, back-to-back reads.
    for (int i = 0; i < 5; i++) begin
      if (i < 4) arm(3, {1'b0, 4'hF, 32'h1000 + 32'(i*4), 32'h0});
      rdv = 32'hA0 + 32'(i) - 32'd1;
      step(i < 4, i > 0, rdv, 1'b0);
    end
    @(negedge clk); #1;
    check("single_err", 70'(err_o), 70'(0));
    check("single_cnt", 70'(gnt_log.size()), 70'(4));

    // Fairness among nodes 0, 2, 5.
    do_reset();
    exp_fair = '{0, 2, 5, 0, 2, 5};
    for (int i = 0; i < 6; i++) begin
      arm(0, rnd_fld()); arm(2, rnd_fld()); arm(5, rnd_fld());
      step(1'b1, i > 0, $urandom, 1'b0);
    end
    step(1'b0, 1'b1, $urandom, 1'b0);
    @(negedge clk); #1;
    check("fair_len", 70'(gnt_log.size()), 70'(6));
    for (int i = 0; i < 6 && i < gnt_log.size(); i++)
      check("fair_order", 70'(gnt_log[i]), 70'(exp_fair[i]));

    // Lock: node 1 presented, bus withholds gnt, node 0 joins.
    do_reset();
    f1 = rnd_fld();
    arm(1, f1);
    step(1'b0, 1'b0, 32'h0, 1'b0);
    arm(0, rnd_fld());
    for (int i = 0; i < 2; i++) begin
      step(1'b0, 1'b0, 32'h0, 1'b0);
      #1 check("lock_addr", 70'(master_req_o[63:32]), 70'(f1[63:32]));
    end
    step(1'b1, 1'b0, 32'h0, 1'b0);
    step(1'b1, 1'b1, $urandom, 1'b0);
    step(1'b0, 1'b1, $urandom, 1'b0);
    @(negedge clk); #1;
    check("lock_len", 70'(gnt_log.size()), 70'(2));
    if (gnt_log.size() == 2) begin
      check("lock_first", 70'(gnt_log[0]), 70'(1));
      check("lock_second", 70'(gnt_log[1]), 70'(0));
    end

    // Backpressure with a full FIFO.
    do_reset();
    arm(0, rnd_fld()); arm(1, rnd_fld()); arm(2, rnd_fld());
    step(1'b1, 1'b0, 32'h0, 1'b0);
    step(1'b1, 1'b0, 32'h0, 1'b0);
    step(1'b1, 1'b0, 32'h0, 1'b0);
    #1 check("stall_req", 70'(master_req_o[69]), 70'(0));
    check("stall_busy", 70'(busy_o), 70'(1));
    step(1'b1, 1'b1, 32'h55, 1'b0);
    #1 check("stall_pop_req", 70'(master_req_o[69]), 70'(0));
    step(1'b1, 1'b1, 32'h66, 1'b0);
    step(1'b0, 1'b1, 32'h77, 1'b0);
    step(1'b0, 1'b1, 32'h88, 1'b0);

    // Spurious response then clear.
    do_reset();
    step(1'b0, 1'b1, 32'h99, 1'b0);
    step(1'b0, 1'b0, 32'h0, 1'b0);
    step(1'b0, 1'b0, 32'h0, 1'b1);
    step(1'b0, 1'b0, 32'h0, 1'b0);
    step(1'b0, 1'b0, 32'h0, 1'b0);

    // Async reset with two outstanding, then a late response.
    do_reset();
    arm(0, rnd_fld()); arm(1, rnd_fld());
    step(1'b1, 1'b0, 32'h0, 1'b0);
    step(1'b1, 1'b0, 32'h0, 1'b0);
    step(1'b0, 1'b0, 32'h0, 1'b0);
    do_reset();
    step(1'b0, 1'b1, 32'h77, 1'b0);
    step(1'b0, 1'b0, 32'h0, 1'b0);
    @(negedge clk); #1;
    check("late_rvalid_err", 70'(err_o), 70'(1));

    // Randomised traffic.
    do_reset();
    for (int c = 0; c < 600; c++) begin
      for (int k = 0; k < NUM_REQ; k++)
        if (!pend[k] && $urandom_range(0, 99) < 25) arm(k, rnd_fld());
      g  = ($urandom_range(0, 99) < 65);
      rv = (outst.size() > 0) && ($urandom_range(0, 1) == 1);
      step(g, rv, $urandom, 1'b0);
    end
    for (int c = 0; c < 20 && outst.size() > 0; c++) step(1'b0, 1'b1, $urandom, 1'b0);
    @(negedge clk); #1;
    check("gnt_q_empty", 70'(gnt_q.size()), 70'(0));
    check("rsp_q_empty", 70'(rsp_q.size()), 70'(0));
    check("final_err", 70'(err_o), 70'(0));

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
`default_nettype wire
